// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
//   Sequencer between a free-running sample source and one FIR instance.
//   Incoming samples are queued in a small FIFO. Each sample is handed to
//   the FIR with a one-cycle start strobe, and the FIR result is captured
//   and offered to the sink on a valid/ready handshake. The block also has
//   a bypass path around the FIR, a saturating overrun counter and a sticky
//   stall timeout.
// Ports
//   ck, rst            clock (posedge), asynchronous active-high reset
//   in_sample/in_valid source samples, 1-cycle strobe, no backpressure
//   bypass             route samples around the FIR (looked at in IDLE only)
//   clr_status         pulse: clear overrun_count and timeout_err
//   fir_in             FIFO head, presented to the FIR
//   fir_input_ready    1-cycle FIR start strobe
//   fir_out            FIR result, valid the cycle after fir_output_ready
//   fir_output_ready   FIR done pulse
//   out_sample         result to sink, valid while out_valid is high
//   out_valid/ready    sink handshake; out_valid held until out_ready
//   busy               FSM not idle or FIFO not empty
//   overrun_count      dropped input samples, saturating
//   timeout_err        sticky: FIR did not respond within TIMEOUT cycles
module fir_stream_ctrl #(
  parameter int N_BITS  = 24,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic signed [N_BITS-1:0] in_sample,
  input  logic                     in_valid,
  input  logic                     bypass,
  input  logic                     clr_status,
  output logic signed [N_BITS-1:0] fir_in,
  output logic                     fir_input_ready,
  input  logic signed [N_BITS-1:0] fir_out,
  input  logic                     fir_output_ready,
  output logic signed [N_BITS-1:0] out_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         overrun_count,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RES = 3'd2,
    S_CAPTURE  = 3'd3,
    S_OUTPUT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [N_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill;
  logic [TW-1:0]     wait_cnt;
  logic              empty, full, push, pop, overrun, timeout_hit;

  assign empty = (fill == '0);
  assign full  = (fill == FULL_CNT);

  // A full FIFO still accepts a sample when the head leaves the same cycle.
  assign push    = in_valid && (!full || pop);
  assign overrun = in_valid && !push;

  // The sample being processed stays at the FIFO head until CAPTURE (or a
  // timeout), so fir_in is stable for the whole FIR transaction.
  assign fir_in          = mem[rd_ptr];
  assign fir_input_ready = (state == S_ISSUE);
  assign out_valid       = (state == S_OUTPUT);
  assign busy            = (state != S_IDLE) || !empty;

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (bypass) begin
            pop       = 1'b1;
            state_nxt = S_OUTPUT;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT_RES;
      S_WAIT_RES: begin
        if (fir_output_ready) begin
          state_nxt = S_CAPTURE;
        end else if (wait_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          pop         = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_CAPTURE: begin
        pop       = 1'b1;
        state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_sample;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      out_sample <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT_RES)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_IDLE && !empty && bypass)
        out_sample <= mem[rd_ptr];
      else if (state == S_CAPTURE)
        out_sample <= fir_out;
    end
  end

  // clr_status has priority over a same-cycle overrun or timeout.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      overrun_count <= '0;
      timeout_err   <= 1'b0;
    end else if (clr_status) begin
      overrun_count <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (overrun && overrun_count != '1)
        overrun_count <= overrun_count + 1'b1;
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
module tb_fir_stream_ctrl;

  localparam int N_BITS  = 24;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;
  localparam int FIR_LAT = 18;
  localparam int COEF [16] = '{-3, 5, -8, 12, -18, 27, -40, 90,
                               90, -40, 27, -18, 12, -8, 5, -3};

  logic                     ck = 1'b0;
  logic                     rst = 1'b1;
  logic signed [N_BITS-1:0] in_sample = '0;
  logic                     in_valid = 1'b0;
  logic                     bypass = 1'b0;
  logic                     clr_status = 1'b0;
  logic signed [N_BITS-1:0] fir_in;
  logic                     fir_input_ready;
  logic signed [N_BITS-1:0] fir_out;
  logic                     fir_output_ready;
  logic signed [N_BITS-1:0] out_sample;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic                     busy;
  logic [CNT_W-1:0]         overrun_count;
  logic                     timeout_err;

  fir_stream_ctrl #(.N_BITS(N_BITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .ck(ck), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .bypass(bypass), .clr_status(clr_status), .fir_in(fir_in),
    .fir_input_ready(fir_input_ready), .fir_out(fir_out),
    .fir_output_ready(fir_output_ready), .out_sample(out_sample),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun_count(overrun_count), .timeout_err(timeout_err)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic signed [N_BITS-1:0] fir_sum(input logic signed [N_BITS-1:0] d [16]);
    longint acc = 0;
    for (int k = 0; k < 16; k++) acc += longint'(COEF[k]) * longint'(d[k]);
    return N_BITS'(acc >>> 7);
  endfunction

  // FIR stand-in: 18 cycles from start strobe to done, result the cycle after.
  logic signed [N_BITS-1:0] stub_dl [16];
  int stub_cnt;
  bit fir_silent = 1'b0;
  always @(posedge ck or posedge rst) begin
    if (rst) begin
      stub_cnt <= 0;
      fir_output_ready <= 1'b0;
      fir_out <= '0;
      for (int i = 0; i < 16; i++) stub_dl[i] <= '0;
    end else begin
      fir_output_ready <= 1'b0;
      if (fir_output_ready) fir_out <= fir_sum(stub_dl);
      if (fir_input_ready && !fir_silent) begin
        stub_dl[0] <= fir_in;
        for (int i = 1; i < 16; i++) stub_dl[i] <= stub_dl[i-1];
        stub_cnt <= FIR_LAT - 1;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) fir_output_ready <= 1'b1;
      end
    end
  end

  // Reference: ordered list of results the sink must see.
  logic signed [N_BITS-1:0] hist [16];
  logic signed [N_BITS-1:0] exp_q [$];

  function automatic void model_push(input logic signed [N_BITS-1:0] x, input bit bp);
    if (bp) begin
      exp_q.push_back(x);
    end else begin
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
      exp_q.push_back(fir_sum(hist));
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) hist[i] = '0;
    exp_q.delete();
  endfunction

  always @(negedge ck) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
      else chk("out_sample", 32'(out_sample), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic send(input logic signed [N_BITS-1:0] x, input bit acc);
    in_valid = 1'b1;
    in_sample = x;
    if (acc) model_push(x, bypass);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int t0, input int lat);
    int n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (!out_valid && n < 300);
    if (out_valid) chk(tag, 32'(cyc - t0), 32'(lat));
    else chk({tag, "_seen"}, 32'(out_valid), 32'd1);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fir_in"}, 32'(fir_in), 32'd0);
    chk({tag, "_fir_input_ready"}, 32'(fir_input_ready), 32'd0);
    chk({tag, "_out_sample"}, 32'(out_sample), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic signed [N_BITS-1:0] x;
    clear_model();

    // Reset state
    repeat (3) @(posedge ck);
    #1;
    check_zero("rst");
    rst = 1'b0;
    tick();

    // Single sample through the FIR: 22-cycle latency
    t0 = cyc;
    send(24'sh000100, 1'b1);
    wait_valid("lat_fir", t0, 22);
    chk("busy_after", 32'(busy), 32'd0);
    wait_idle("single");

    // Bypass: -5 then 7 on consecutive cycles
    bypass = 1'b1;
    t0 = cyc;
    send(-24'sd5, 1'b1);
    send(24'sd7, 1'b1);
    wait_valid("lat_bypass", t0, 2);
    wait_idle("bypass");
    bypass = 1'b0;

    // Sink stalled: only DEPTH+1 samples retained, the 6th is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = N_BITS'($urandom);
      send(x, i < DEPTH + 1);
      repeat (29) tick();
      if (i == DEPTH) chk("overrun_before", 32'(overrun_count), 32'd0);
    end
    chk("overrun_after", 32'(overrun_count), 32'd1);
    out_ready = 1'b1;
    wait_idle("stall");
    chk("overrun_hold", 32'(overrun_count), 32'd1);
    pulse_clr();
    chk("overrun_clr", 32'(overrun_count), 32'd0);

    // Full FIFO: a sample in mid-wait is dropped, one on the CAPTURE cycle is kept
    for (int c = 0; c <= 21; c++) begin
      if (c < 4 || c == 10 || c == 21) begin
        x = N_BITS'($urandom);
        in_valid = 1'b1;
        in_sample = x;
        if (c != 10) model_push(x, 1'b0);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("overrun_full_pop", 32'(overrun_count), 32'd1);
    wait_idle("full_pop");
    pulse_clr();

    // FIR never answers: timeout after TIMEOUT cycles in WAIT_RES
    fir_silent = 1'b1;
    t0 = cyc;
    send(24'sh123456, 1'b0);
    repeat (65) tick();
    chk("timeout_early", 32'(timeout_err), 32'd0);
    tick();
    chk("timeout_set", 32'(timeout_err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    fir_silent = 1'b0;
    t0 = cyc;
    send(24'sh0abcde, 1'b1);
    wait_valid("lat_after_tmo", t0, 22);
    wait_idle("after_tmo");
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    pulse_clr();
    chk("timeout_clr", 32'(timeout_err), 32'd0);

    // Reset while waiting on the FIR
    send(24'sh3c3c3c, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    clear_model();
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;
    tick();
    t0 = cyc;
    send(-24'sd1000, 1'b1);
    wait_valid("lat_after_rst", t0, 22);
    wait_idle("after_rst");

    // Randomized phases: random samples, gaps and sink stalls
    for (int ph = 0; ph < 4; ph++) begin
      int sent = 0;
      int gap = 0;
      bypass = ($urandom % 2) != 0;
      while (sent < 8) begin
        out_ready = ($urandom % 4) != 0;
        if (gap == 0) begin
          x = N_BITS'($urandom);
          in_valid = 1'b1;
          in_sample = x;
          model_push(x, bypass);
          sent++;
          gap = $urandom_range(25, 40);
        end else begin
          in_valid = 1'b0;
          gap--;
        end
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle("rand");
    end
    bypass = 1'b0;
    chk("rand_overrun", 32'(overrun_count), 32'd0);
    chk("rand_timeout", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
